// File: rtl/cluster_1_frame_sequencer.sv
// Frame sequencer for the cluster_1 per-bit output modules.
// Assembles the wide input vector from a word stream and holds it on the shared bus.
// After a fixed settle time it captures the modules' outputs and offers them
// over a valid/ready handshake.
module cluster_1_frame_sequencer #(
   parameter int IN_W   = 1894,
   parameter int WORD_W = 32,
   parameter int OUT_W  = 128,
   parameter int SETTLE = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_last,
   output logic [IN_W-1:0]   i,
   input  logic [OUT_W-1:0]  o_bits,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [OUT_W-1:0]  res_data,
   output logic              res_err
);

   localparam int NWORDS = (IN_W + WORD_W - 1) / WORD_W;
   // Bits carried by the final, possibly truncated, word.
   localparam int LAST_W = IN_W - (NWORDS - 1) * WORD_W;
   localparam int KW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [KW-1:0] LAST_IDX  = KW'(NWORDS - 1);
   localparam logic [3:0]    SETTLE_LD = 4'(SETTLE - 1);

   typedef enum logic [1:0] {ST_LOAD, ST_WAIT, ST_HOLD} state_t;

   state_t            state_q, state_d;
   logic [KW-1:0]     k_q, k_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              err_q, err_d;
   logic [IN_W-1:0]   i_q, i_d;
   logic [OUT_W-1:0]  res_data_q, res_data_d;
   logic              res_err_q, res_err_d;
   logic              res_valid_q, res_valid_d;

   logic              accept;
   logic              last_word;
   logic              frame_end;

   assign accept    = in_valid & in_ready;
   assign last_word = (k_q == LAST_IDX);
   // A frame closes on the final word index or on an early in_last.
   assign frame_end = accept & (last_word | in_last);

   // State and datapath registers, cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_LOAD;
         k_q         <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         i_q         <= '0;
         res_data_q  <= '0;
         res_err_q   <= 1'b0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         i_q         <= i_d;
         res_data_q  <= res_data_d;
         res_err_q   <= res_err_d;
         res_valid_q <= res_valid_d;
      end
   end

   // Next-state logic: LOAD -> WAIT on frame end, WAIT -> HOLD at settle, HOLD -> LOAD on handshake.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_LOAD: if (frame_end)      state_d = ST_WAIT;
         ST_WAIT: if (cnt_q == 4'd0)  state_d = ST_HOLD;
         ST_HOLD: if (res_ready)      state_d = ST_LOAD;
         default:                     state_d = ST_LOAD;
      endcase
   end

   // Outputs decoded purely from registered state.
   always_comb begin
      in_ready = (state_q == ST_LOAD);
   end

   // Word assembly, settle countdown, result capture and frame clear.
   always_comb begin
      k_d         = k_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      i_d         = i_q;
      res_data_d  = res_data_q;
      res_err_d   = res_err_q;
      res_valid_d = res_valid_q;
      case (state_q)
         ST_LOAD: begin
            if (accept) begin
               for (int w = 0; w < NWORDS - 1; w++) begin
                  if (k_q == KW'(w)) i_d[w*WORD_W +: WORD_W] = in_data;
               end
               // The final word only fills the bits that exist; the rest is dropped.
               if (last_word) i_d[IN_W-1 -: LAST_W] = in_data[LAST_W-1:0];
               if (frame_end) begin
                  k_d   = '0;
                  cnt_d = SETTLE_LD;
                  // Clean only when in_last lands exactly on the final word.
                  if (!(last_word && in_last)) err_d = 1'b1;
               end else begin
                  k_d = k_q + KW'(1);
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               res_data_d  = o_bits;
               res_err_d   = err_q;
               res_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_HOLD: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               i_d         = '0;
               err_d       = 1'b0;
            end
         end
         default: ;
      endcase
   end

   assign i         = i_q;
   assign res_data  = res_data_q;
   assign res_err   = res_err_q;
   assign res_valid = res_valid_q;

endmodule
